rr_mux4_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares the existing 4:1 4-bit mux datapath (mux4_1_4b) among four requesters.
- Picks one requesting port and drives the mux select. Captures the selected 4-bit word into an output register and presents it downstream with a valid/ready handshake.
- Acknowledges the winning requester and counts completed transfers.
- Sits between four 4-bit producers and one shared 4-bit consumer channel.

---
 rtl/rr_mux4_pkg.sv | 25 ++
 rtl/rr_mux4_arb_if.sv | 31 +++
 rtl/mux4_1_4b.sv | 23 ++
 rtl/rr_pick4.sv | 28 ++
 rtl/rr_mux4_arb.sv | 91 +++++++++
 tb/tb_rr_mux4_arb.sv | 249 ++++++++++++++++++++++++
 6 files changed

// File: rtl/rr_mux4_pkg.sv
// Shared types and constants for the four-port round-robin mux arbiter.
// Imported by the picker, the handshake interface and the top.
package rr_mux4_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam int NPORT  = 4;
  localparam int SEL_W  = 2;
  localparam int DATA_W = 4;

  localparam logic [SEL_W-1:0] PTR_RST = 2'd3;

  function automatic logic [NPORT-1:0] onehot(
    input logic [SEL_W-1:0] i
  );
    logic [NPORT-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_mux4_arb_if.sv
// Producer/consumer bundle of the arbiter: four request ports plus
// the registered downstream valid/ready channel and status.
interface rr_mux4_arb_if
  import rr_mux4_pkg::*;
#(
  parameter int CNT_W = 8
) ();

  logic [NPORT-1:0]  req;
  logic [DATA_W-1:0] inA;
  logic [DATA_W-1:0] inB;
  logic [DATA_W-1:0] inC;
  logic [DATA_W-1:0] inD;
  logic              out_ready;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic [SEL_W-1:0]  sel;
  logic [NPORT-1:0]  ack;
  logic [CNT_W-1:0]  xfer_cnt;

  modport master (
    output req, inA, inB, inC, inD, out_ready,
    input  out, out_valid, sel, ack, xfer_cnt
  );

  modport slave (
    input  req, inA, inB, inC, inD, out_ready,
    output out, out_valid, sel, ack, xfer_cnt
  );

endinterface

// File: rtl/mux4_1_4b.sv
// Shared 4:1 mux of 4-bit words.
// Only the selected input reaches y.
module mux4_1_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] c,
  input  logic [3:0] d,
  input  logic [1:0] s,
  output logic [3:0] y
);

  always_comb begin
    y = 4'd0;
    unique case (s)
      2'd0: y = a;
      2'd1: y = b;
      2'd2: y = c;
      2'd3: y = d;
      default: y = 4'd0;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first eligible port after ptr,
// wrapping around so ptr itself is checked last.
module rr_pick4
  import rr_mux4_pkg::*;
(
  input  logic [NPORT-1:0] eligible,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] winner
);

  logic [SEL_W-1:0] idx;

  // Walk farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    any    = 1'b0;
    winner = ptr;
    idx    = '0;
    for (int k = NPORT; k >= 1; k--) begin
      idx = ptr + SEL_W'(k);
      if (eligible[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/rr_mux4_arb.sv
// Round-robin arbiter sharing mux4_1_4b among four 4-bit producers,
// with a registered valid/ready output and saturating transfer count.
module rr_mux4_arb
  import rr_mux4_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  rr_mux4_arb_if.slave  bus
);

  state_t            state_q;
  state_t            state_d;
  logic [SEL_W-1:0]  ptr_q;
  logic [DATA_W-1:0] out_q;
  logic [SEL_W-1:0]  sel_q;
  logic [NPORT-1:0]  ack_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [NPORT-1:0]  eligible;
  logic              any;
  logic [SEL_W-1:0]  winner;
  logic [DATA_W-1:0] mux_y;
  logic              valid;
  logic              can_load;
  logic              grant;
  logic              xfer;

  // A port whose ack is visible cannot win again for the same word.
  assign eligible = bus.req & ~ack_q;
  assign valid    = (state_q == FULL);
  assign can_load = !valid || bus.out_ready;
  assign grant    = can_load && any;
  assign xfer     = valid && bus.out_ready;

  rr_pick4 u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .any      (any),
    .winner   (winner)
  );

  mux4_1_4b u_mux (
    .a (bus.inA),
    .b (bus.inB),
    .c (bus.inC),
    .d (bus.inD),
    .s (winner),
    .y (mux_y)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (grant) state_d = FULL;
      FULL: if (bus.out_ready && !grant) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      out_q   <= '0;
      sel_q   <= '0;
      ack_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= '0;
      if (grant) begin
        out_q <= mux_y;
        sel_q <= winner;
        ack_q <= onehot(winner);
        ptr_q <= winner;
      end
      if (xfer && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid;
  assign bus.sel       = sel_q;
  assign bus.ack       = ack_q;
  assign bus.xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_mux4_arb.sv
// Directed and constrained-random bench for rr_mux4_arb.
// Inputs change and outputs are sampled on the falling edge.
module tb_rr_mux4_arb;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  rr_mux4_arb_if #(.CNT_W(8)) bus ();

  rr_mux4_arb #(.CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b1111;
    tick();
    tick();
    n_cmp++;
    if (bus.out !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_out got=%h exp=0", bus.out);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid got=%b exp=0", bus.out_valid);
    end
    n_cmp++;
    if (bus.sel !== 2'd0 || bus.ack !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_sel_ack got=%0d/%b exp=0/0000",
               bus.sel, bus.ack);
    end
    n_cmp++;
    if (bus.xfer_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_cnt got=%0d exp=0", bus.xfer_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bus.req = 4'b0100;
    bus.inC = 4'hA;
    bus.out_ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.out !== 4'hA || bus.sel !== 2'd2) begin
      n_bad++;
      $display("FAIL single_word got=%h/%0d exp=a/2", bus.out, bus.sel);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.ack !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_ack got=%b/%b exp=1/0100",
               bus.out_valid, bus.ack);
    end
    bus.req = 4'b0000;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.ack !== 4'd0) begin
      n_bad++;
      $display("FAIL single_drain got=%b/%b exp=0/0000",
               bus.out_valid, bus.ack);
    end
    n_cmp++;
    if (bus.xfer_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL single_cnt got=%0d exp=1", bus.xfer_cnt);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] e_out [5];
    logic [1:0] e_sel [5];
    logic [3:0] e_ack [5];
    e_out = '{4'h1, 4'h8, 4'hA, 4'h5, 4'h1};
    e_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    e_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req = 4'b0000;
    do_reset();
    bus.inA = 4'h1;
    bus.inB = 4'h8;
    bus.inC = 4'hA;
    bus.inD = 4'h5;
    bus.req = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (bus.out !== e_out[i] || bus.sel !== e_sel[i] ||
          bus.ack !== e_ack[i] || bus.out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL fair_%0d got=%h/%0d/%b/%b exp=%h/%0d/%b/1", i,
                 bus.out, bus.sel, bus.ack, bus.out_valid,
                 e_out[i], e_sel[i], e_ack[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bus.req = 4'b0000;
    do_reset();
    bus.req = 4'b1111;
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (bus.out !== 4'h8 || bus.sel !== 2'd1 ||
          bus.ack !== 4'd0 || bus.out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold_%0d got=%h/%0d/%b/%b exp=8/1/0000/1", i,
                 bus.out, bus.sel, bus.ack, bus.out_valid);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.out !== 4'hA || bus.sel !== 2'd2 || bus.ack !== 4'b0100) begin
      n_bad++;
      $display("FAIL bp_release got=%h/%0d/%b exp=a/2/0100",
               bus.out, bus.sel, bus.ack);
    end
    n_cmp++;
    if (bus.xfer_cnt !== 8'd2) begin
      n_bad++;
      $display("FAIL bp_cnt got=%0d exp=2", bus.xfer_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.xfer_cnt !== 8'd0 ||
        bus.ack !== 4'd0) begin
      n_bad++;
      $display("FAIL midrst got=%b/%0d/%b exp=0/0/0000",
               bus.out_valid, bus.xfer_cnt, bus.ack);
    end
    bus.req = 4'b1010;
    tick();
    n_cmp++;
    if (bus.sel !== 2'd1 || bus.ack !== 4'b0010 || bus.out !== 4'h8) begin
      n_bad++;
      $display("FAIL midrst_first got=%0d/%b/%h exp=1/0010/8",
               bus.sel, bus.ack, bus.out);
    end
  endtask

  task automatic test_back_to_back();
    bus.req = 4'b0000;
    do_reset();
    bus.req = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    n_cmp++;
    if (bus.xfer_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL saturate got=%0d exp=255", bus.xfer_cnt);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] d [4];
    r = 4'b0000;
    d = '{4'h0, 4'h0, 4'h0, 4'h0};
    bus.req = r;
    do_reset();
    for (int cyc = 0; cyc < 320; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.ack[i]) begin
          n_cmp++;
          if (bus.out !== d[i] || bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rand_ack%0d cyc=%0d got=%h/%b exp=%h/1",
                     i, cyc, bus.out, bus.out_valid, d[i]);
          end
        end
      end
      n_cmp++;
      if ($countones(bus.ack) > 1) begin
        n_bad++;
        $display("FAIL rand_onehot cyc=%0d got=%b exp=at most one",
                 cyc, bus.ack);
      end
      for (int i = 0; i < 4; i++) begin
        if (!r[i] || bus.ack[i]) begin
          r[i] = 1'($urandom_range(0, 1));
          d[i] = 4'($urandom_range(0, 15));
        end
      end
      bus.req = r;
      bus.inA = d[0];
      bus.inB = d[1];
      bus.inC = d[2];
      bus.inD = d[3];
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.req = 4'b0000;
    bus.inA = 4'h0;
    bus.inB = 4'h0;
    bus.inC = 4'h0;
    bus.inD = 4'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
